pitch_peak_tracker: RTL and testbench

- Parametrised successor to the autocorrelation peak search in the audio pitch path.
- Accepts autocorrelation values as a valid/ready stream, one lag per beat, instead of a wide parallel array.
- Finds the strongest lag inside a programmable window and converts it to pitch in Hz with a sequential divider.
- Reports voicing and a done pulse for the display/audio control logic downstream.

---
 rtl/pitch_peak_tracker.sv | 239 +++++++++++++++++++++++
 tb/tb_pitch_peak_tracker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pitch_peak_tracker.sv
// pitch_peak_tracker
// Streams one autocorrelation value per lag. It finds the strongest lag inside
// [LAG_MIN, LAG_MAX], and a restoring divider converts that lag to pitch = FS / lag.
// Optional build macro PITCH_MEDIAN3_EN adds median-of-three smoothing of voiced pitch.
module pitch_peak_tracker #(
    parameter int DATA_W  = 72,
    parameter int IDX_W   = 10,
    parameter int LAG_MIN = 47,
    parameter int LAG_MAX = 141,
    parameter int FS      = 12000,
    parameter int PITCH_W = 14
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               is_voice,
    input  logic [DATA_W-1:0]  corr_data,
    input  logic               corr_valid,
    output logic               corr_ready,
    output logic               busy,
    output logic               done,
    output logic               voiced,
    output logic [IDX_W-1:0]   peak_idx,
    output logic [DATA_W-1:0]  peak_val,
    output logic [PITCH_W-1:0] pitch
);

    localparam int CNT_W = $clog2(PITCH_W + 1);
    localparam logic [IDX_W-1:0]   LAG_MIN_I = IDX_W'(LAG_MIN);
    localparam logic [IDX_W-1:0]   LAG_MAX_I = IDX_W'(LAG_MAX);
    // The quotient fits in PITCH_W bits, so only the low PITCH_W dividend bits are
    // shifted in. The bits above them preload the partial remainder, which is
    // always smaller than the divisor.
    localparam logic [PITCH_W-1:0] FS_LO     = PITCH_W'(FS);
    localparam logic [IDX_W-1:0]   FS_HI     = IDX_W'(FS >> PITCH_W);
    localparam logic [CNT_W-1:0]   DIV_LAST  = CNT_W'(PITCH_W - 1);
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DIVIDE, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic                       voice_q, voice_d;
    logic [IDX_W-1:0]           lag_q, lag_d;
    logic signed [DATA_W-1:0]   max_q, max_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [IDX_W-1:0]           rem_q, rem_d;
    logic [PITCH_W-1:0]         quo_q, quo_d;
    logic [PITCH_W-1:0]         dvd_q, dvd_d;
    logic [CNT_W-1:0]           div_cnt_q, div_cnt_d;
    logic                       corr_ready_q, corr_ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       voiced_q, voiced_d;
    logic [IDX_W-1:0]           peak_idx_q, peak_idx_d;
    logic [DATA_W-1:0]          peak_val_q, peak_val_d;
    logic [PITCH_W-1:0]         pitch_q, pitch_d;

    logic [IDX_W:0]             rem_shift;
    logic                       rem_ge;
    logic                       frame_voiced;
    logic                       in_window;

`ifdef PITCH_MEDIAN3_EN
    logic [PITCH_W-1:0]         hist0_q, hist0_d;
    logic [PITCH_W-1:0]         hist1_q, hist1_d;
    logic [1:0]                 hist_cnt_q, hist_cnt_d;

    function automatic logic [PITCH_W-1:0] med3(input logic [PITCH_W-1:0] a,
                                                 input logic [PITCH_W-1:0] b,
                                                 input logic [PITCH_W-1:0] c);
        logic [PITCH_W-1:0] lo;
        logic [PITCH_W-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)      return lo;
        else if (c > hi) return hi;
        else             return c;
    endfunction
`endif

    // Next-state logic: frame control, running peak search, divider steps and result capture
    always_comb begin
        state_d      = state_q;
        voice_d      = voice_q;
        lag_d        = lag_q;
        max_d        = max_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvd_d        = dvd_q;
        div_cnt_d    = div_cnt_q;
        corr_ready_d = corr_ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        voiced_d     = voiced_q;
        peak_idx_d   = peak_idx_q;
        peak_val_d   = peak_val_q;
        pitch_d      = pitch_q;
`ifdef PITCH_MEDIAN3_EN
        hist0_d      = hist0_q;
        hist1_d      = hist1_q;
        hist_cnt_d   = hist_cnt_q;
`endif

        rem_shift    = {rem_q, dvd_q[PITCH_W-1]};
        rem_ge       = (rem_shift >= {1'b0, idx_q});
        frame_voiced = voice_q && !max_q[DATA_W-1] && (max_q != '0);
        in_window    = (lag_q >= LAG_MIN_I) && (lag_q <= LAG_MAX_I);

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse belongs to the finished frame.
                if (start && !done_q) begin
                    voice_d      = is_voice;
                    lag_d        = '0;
                    max_d        = MOST_NEG;
                    idx_d        = LAG_MIN_I;
                    busy_d       = 1'b1;
                    corr_ready_d = 1'b1;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (corr_valid && corr_ready_q) begin
                    // Strict compare: ties keep the earliest lag.
                    if (in_window && ($signed(corr_data) > max_q)) begin
                        max_d = $signed(corr_data);
                        idx_d = lag_q;
                    end
                    lag_d = lag_q + 1'b1;
                    if (lag_q == LAG_MAX_I) begin
                        corr_ready_d = 1'b0;
                        rem_d        = FS_HI;
                        quo_d        = '0;
                        dvd_d        = FS_LO;
                        div_cnt_d    = '0;
                        state_d      = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                // Unvoiced frames still spend PITCH_W cycles here to keep latency constant.
                if (frame_voiced) begin
                    rem_d = rem_ge ? IDX_W'(rem_shift - {1'b0, idx_q}) : rem_shift[IDX_W-1:0];
                    quo_d = {quo_q[PITCH_W-2:0], rem_ge};
                    dvd_d = {dvd_q[PITCH_W-2:0], 1'b0};
                end
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == DIV_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                voiced_d   = frame_voiced;
                peak_idx_d = idx_q;
                peak_val_d = max_q;
`ifdef PITCH_MEDIAN3_EN
                if (!frame_voiced) begin
                    pitch_d    = '0;
                    hist_cnt_d = '0;
                end else begin
                    pitch_d    = (hist_cnt_q == 2'd2) ? med3(quo_q, hist0_q, hist1_q) : quo_q;
                    hist1_d    = hist0_q;
                    hist0_d    = quo_q;
                    if (hist_cnt_q != 2'd2) begin
                        hist_cnt_d = hist_cnt_q + 2'd1;
                    end
                end
`else
                pitch_d    = frame_voiced ? quo_q : '0;
`endif
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            voice_q      <= 1'b0;
            lag_q        <= '0;
            max_q        <= '0;
            idx_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvd_q        <= '0;
            div_cnt_q    <= '0;
            corr_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            voiced_q     <= 1'b0;
            peak_idx_q   <= '0;
            peak_val_q   <= '0;
            pitch_q      <= '0;
`ifdef PITCH_MEDIAN3_EN
            hist0_q      <= '0;
            hist1_q      <= '0;
            hist_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            voice_q      <= voice_d;
            lag_q        <= lag_d;
            max_q        <= max_d;
            idx_q        <= idx_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvd_q        <= dvd_d;
            div_cnt_q    <= div_cnt_d;
            corr_ready_q <= corr_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            voiced_q     <= voiced_d;
            peak_idx_q   <= peak_idx_d;
            peak_val_q   <= peak_val_d;
            pitch_q      <= pitch_d;
`ifdef PITCH_MEDIAN3_EN
            hist0_q      <= hist0_d;
            hist1_q      <= hist1_d;
            hist_cnt_q   <= hist_cnt_d;
`endif
        end
    end

    assign corr_ready = corr_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign voiced     = voiced_q;
    assign peak_idx   = peak_idx_q;
    assign peak_val   = peak_val_q;
    assign pitch      = pitch_q;

endmodule

// File: tb/tb_pitch_peak_tracker.sv
// Testbench for pitch_peak_tracker: directed frames, a frame-level reference model
// and a per-cycle comparison of every output against the model's expectation.
module tb_pitch_peak_tracker;

    localparam int DATA_W  = 72;
    localparam int IDX_W   = 10;
    localparam int LAG_MIN = 47;
    localparam int LAG_MAX = 141;
    localparam int FS      = 12000;
    localparam int PITCH_W = 14;

    logic               Clk        = 1'b0;
    logic               Reset_n    = 1'b1;
    logic               start      = 1'b0;
    logic               is_voice   = 1'b0;
    logic [DATA_W-1:0]  corr_data  = '0;
    logic               corr_valid = 1'b0;
    logic               corr_ready;
    logic               busy;
    logic               done;
    logic               voiced;
    logic [IDX_W-1:0]   peak_idx;
    logic [DATA_W-1:0]  peak_val;
    logic [PITCH_W-1:0] pitch;

    pitch_peak_tracker #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .LAG_MIN(LAG_MIN),
        .LAG_MAX(LAG_MAX), .FS(FS), .PITCH_W(PITCH_W)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .is_voice(is_voice),
        .corr_data(corr_data), .corr_valid(corr_valid), .corr_ready(corr_ready),
        .busy(busy), .done(done), .voiced(voiced), .peak_idx(peak_idx),
        .peak_val(peak_val), .pitch(pitch)
    );

    always #5 Clk = ~Clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;

    // Expected output values, maintained by the stimulus/model
    logic               exp_ready  = 1'b0;
    logic               exp_busy   = 1'b0;
    logic               exp_done   = 1'b0;
    logic               exp_voiced = 1'b0;
    logic [IDX_W-1:0]   exp_idx    = '0;
    logic [DATA_W-1:0]  exp_val    = '0;
    logic [PITCH_W-1:0] exp_pitch  = '0;

    logic signed [DATA_W-1:0] smp [0:LAG_MAX];
    int hist[$];

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle comparison on the falling edge
    always @(negedge Clk) begin
        if (chk_en) begin
            cmp("corr_ready", {127'd0, corr_ready}, {127'd0, exp_ready});
            cmp("busy",       {127'd0, busy},       {127'd0, exp_busy});
            cmp("done",       {127'd0, done},       {127'd0, exp_done});
            cmp("voiced",     {127'd0, voiced},     {127'd0, exp_voiced});
            cmp("peak_idx",   128'(peak_idx),       128'(exp_idx));
            cmp("peak_val",   128'(peak_val),       128'(exp_val));
            cmp("pitch",      128'(pitch),          128'(exp_pitch));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic fill(input logic signed [DATA_W-1:0] v);
        for (int l = 0; l <= LAG_MAX; l++) smp[l] = v;
    endtask

    // Frame-level reference: windowed argmax (first wins), voicing rule, FS/lag, median history
    task automatic model_result(input bit voice);
        logic signed [DATA_W-1:0] m_max;
        int m_idx;
        bit v;
        int raw;
        int p;
        m_max = {1'b1, {(DATA_W-1){1'b0}}};
        m_idx = LAG_MIN;
        for (int l = LAG_MIN; l <= LAG_MAX; l++) begin
            if (smp[l] > m_max) begin
                m_max = smp[l];
                m_idx = l;
            end
        end
        v   = voice && (m_max > 0);
        raw = v ? FS / m_idx : 0;
        p   = raw;
`ifdef PITCH_MEDIAN3_EN
        if (!v) begin
            hist.delete();
        end else begin
            hist.push_front(raw);
            if (hist.size() > 3) void'(hist.pop_back());
            if (hist.size() == 3) begin
                int a, b, c, mx, mn;
                a = hist[0]; b = hist[1]; c = hist[2];
                mx = (a > b) ? a : b; mx = (mx > c) ? mx : c;
                mn = (a < b) ? a : b; mn = (mn < c) ? mn : c;
                p  = a + b + c - mx - mn;
            end
        end
`endif
        exp_done   = 1'b1;
        exp_busy   = 1'b0;
        exp_voiced = v;
        exp_idx    = IDX_W'(m_idx);
        exp_val    = m_max;
        exp_pitch  = PITCH_W'(p);
    endtask

    // Drives one frame with valid gaps, a stray start mid-scan, a refused extra beat and
    // a start coincident with done. abort_at >= 0 pulls reset low before that lag.
    task automatic run_frame(input string tag, input bit voice, input int abort_at);
        start = 1'b1; is_voice = voice; corr_valid = 1'b0;
        tick();
        start = 1'b0; is_voice = ~voice;
        exp_busy = 1'b1; exp_ready = 1'b1;
        for (int lag = 0; lag <= LAG_MAX; lag++) begin
            if (lag == 20 || lag == 100) begin
                corr_valid = 1'b0; corr_data = {4'b0111, 68'd0};
                tick();
            end
            if (lag == abort_at) begin
                Reset_n = 1'b0; corr_valid = 1'b0;
                exp_ready = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_voiced = 1'b0;
                exp_idx = '0; exp_val = '0; exp_pitch = '0;
                hist.delete();
                tick(); tick();
                Reset_n = 1'b1;
                tick();
                $display("frame %s: aborted by reset at lag %0d", tag, lag);
                return;
            end
            corr_valid = 1'b1; corr_data = smp[lag]; start = (lag == 10);
            tick();
            start = 1'b0;
        end
        exp_ready = 1'b0;
        corr_data = {4'b0111, 68'd0};
        for (int i = 1; i <= 14; i++) begin
            tick();
            corr_valid = 1'b0;
        end
        tick();
        model_result(voice);
        start = 1'b1; is_voice = 1'b1;
        tick();
        start = 1'b0; is_voice = 1'b0; exp_done = 1'b0;
        tick();
        $display("frame %s: voiced=%0d peak_idx=%0d pitch=%0d", tag, voiced, peak_idx, pitch);
    endtask

    initial begin
        fill('0);
        #2 Reset_n = 1'b0;
        chk_en = 1'b1;
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        fill(-5); smp[60] = 1000;
        run_frame("basic", 1'b1, -1);
        cmp("lit basic peak_idx", 128'(peak_idx), 128'd60);
        cmp("lit basic peak_val", 128'(peak_val), 128'd1000);
        cmp("lit basic pitch",    128'(pitch),    128'd200);
        cmp("lit basic voiced",   128'(voiced),   128'd1);

        fill(-5); smp[80] = 500; smp[100] = 500;
        run_frame("tie", 1'b1, -1);
        cmp("lit tie peak_idx", 128'(peak_idx), 128'd80);
        cmp("lit tie pitch",    128'(pitch),    128'd150);

        fill(-5); smp[30] = 9999; smp[47] = 7;
        run_frame("below_window", 1'b1, -1);
        cmp("lit below peak_idx", 128'(peak_idx), 128'd47);
`ifndef PITCH_MEDIAN3_EN
        cmp("lit below pitch",    128'(pitch),    128'd255);
`endif

        fill(-5); smp[46] = 1000000; smp[141] = 9;
        run_frame("lag_max", 1'b1, -1);
        cmp("lit lagmax peak_idx", 128'(peak_idx), 128'd141);

        fill(-5); smp[70] = {3'b001, 69'd1}; smp[71] = 5;
        run_frame("wide", 1'b1, -1);
        cmp("lit wide peak_idx", 128'(peak_idx), 128'd70);

        fill(-5); smp[100] = -3; smp[60] = {2'b10, 70'd5000};
        run_frame("all_negative", 1'b1, -1);
        cmp("lit neg voiced",   128'(voiced),   128'd0);
        cmp("lit neg pitch",    128'(pitch),    128'd0);
        cmp("lit neg peak_idx", 128'(peak_idx), 128'd100);

        fill(-5); smp[90] = 777;
        run_frame("is_voice0", 1'b0, -1);
        cmp("lit novoice voiced", 128'(voiced), 128'd0);
        cmp("lit novoice pitch",  128'(pitch),  128'd0);

        fill('0);
        run_frame("zeros", 1'b1, -1);
        cmp("lit zeros voiced",   128'(voiced),   128'd0);
        cmp("lit zeros peak_idx", 128'(peak_idx), 128'd47);

        fill(-5); smp[60] = 1000;
        run_frame("abort", 1'b1, 70);
        fill(-5); smp[120] = 400;
        run_frame("after_abort", 1'b1, -1);
        cmp("lit abort peak_idx", 128'(peak_idx), 128'd120);
        cmp("lit abort pitch",    128'(pitch),    128'd100);

        fill(-5); smp[90] = 777;
        run_frame("clear", 1'b0, -1);
        fill(-5); smp[60] = 1000;
        run_frame("seq60", 1'b1, -1);
        cmp("lit seq60 pitch", 128'(pitch), 128'd200);
        fill(-5); smp[120] = 1000;
        run_frame("seq120", 1'b1, -1);
        cmp("lit seq120 pitch", 128'(pitch), 128'd100);
        fill(-5); smp[80] = 1000;
        run_frame("seq80", 1'b1, -1);
        cmp("lit seq80 pitch", 128'(pitch), 128'd150);
        fill(-5);
        run_frame("seq_unvoiced", 1'b1, -1);
        cmp("lit sequv pitch", 128'(pitch), 128'd0);

        tick(); tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
